// File: rtl/simple_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions,
// named glyphs, the hex decode table and the scan FSM encoding.
package simple_pkg;

  localparam int unsigned SEG_A_BIT  = 7;
  localparam int unsigned SEG_B_BIT  = 6;
  localparam int unsigned SEG_C_BIT  = 5;
  localparam int unsigned SEG_D_BIT  = 4;
  localparam int unsigned SEG_E_BIT  = 3;
  localparam int unsigned SEG_F_BIT  = 2;
  localparam int unsigned SEG_G_BIT  = 1;
  localparam int unsigned SEG_DP_BIT = 0;

  localparam logic [7:0] SEG_E     = 8'b10011110;
  localparam logic [7:0] SEG_H     = 8'b01101110;
  localparam logic [7:0] SEG_F     = 8'b10001110;
  localparam logic [7:0] SEG_O     = 8'b00111010;
  localparam logic [7:0] SEG_BLANK = 8'b00000000;

  // Bit order a..g, dp; dp is always clear in the table
  localparam logic [7:0] HEX_TABLE [16] = '{
    8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
    8'b11111110, 8'b11110110, 8'b11101110, 8'b00111110,
    8'b10011100, 8'b01111010, 8'b10011110, 8'b10001110
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit hex to seven-segment decoder with pass-through dp.
module hex7seg
  import simple_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph             = HEX_TABLE[hex];
    seg               = glyph;
    seg[SEG_DP_BIT]   = dp;
  end

endmodule

// File: rtl/segment_scanner.sv
// Time-multiplexed seven-segment driver: per-frame shadowed digits, a blank gap
// between digits, registered segment bus and one-hot digit enables.
module segment_scanner
  import simple_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int DWELL   = 1024,
  parameter int BLANK   = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [8*NDIGITS-1:0]       digit_in,
  input  logic [NDIGITS-1:0]         raw_mask,
  input  logic                       freeze,
  output logic [7:0]                 segments,
  output logic [NDIGITS-1:0]         digit_sel,
  output logic                       frame_pulse,
  output logic [$clog2(NDIGITS)-1:0] cur_digit
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DW   = $clog2(NDIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NDIGITS - 1);

  scan_state_t         state;
  logic [CW-1:0]       cnt;
  logic                init;
  logic [7:0]          shadow [NDIGITS];
  logic [NDIGITS-1:0]  shadow_raw;

  logic [7:0]          cur_byte;
  logic                cur_raw;
  logic [7:0]          dec_pat;
  logic [7:0]          next_pat;
  logic                dwell_done;
  logic                blank_done;
  logic                wrap;
  logic                reload;

  assign dwell_done = (state == ST_SCAN)  && (cnt == DWELL_LAST);
  assign blank_done = (state == ST_BLANK) && (cnt == BLANK_LAST);
  assign wrap       = dwell_done && (cur_digit == DIGIT_LAST);
  // The first edge after reset counts as entry into BLANK at digit 0
  assign reload     = !freeze && (init || wrap);

  assign cur_byte = shadow[cur_digit];
  assign cur_raw  = shadow_raw[cur_digit];

  hex7seg u_hex7seg (
    .hex (cur_byte[3:0]),
    .dp  (cur_byte[4]),
    .seg (dec_pat)
  );

  assign next_pat = cur_raw ? cur_byte : dec_pat;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_raw <= '1;
      for (int unsigned i = 0; i < NDIGITS; i++) shadow[i] <= '0;
    end else if (reload) begin
      shadow_raw <= raw_mask;
      for (int unsigned i = 0; i < NDIGITS; i++) shadow[i] <= digit_in[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      init        <= 1'b1;
      cur_digit   <= '0;
      segments    <= SEG_BLANK;
      digit_sel   <= '0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      if (init) begin
        init  <= 1'b0;
        state <= ST_BLANK;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_BLANK: begin
            if (blank_done) begin
              state     <= ST_SCAN;
              cnt       <= '0;
              segments  <= next_pat;
              digit_sel <= {{(NDIGITS-1){1'b0}}, 1'b1} << cur_digit;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_SCAN: begin
            if (dwell_done) begin
              state     <= ST_BLANK;
              cnt       <= '0;
              segments  <= SEG_BLANK;
              digit_sel <= '0;
              if (wrap) begin
                cur_digit   <= '0;
                frame_pulse <= 1'b1;
              end else begin
                cur_digit <= cur_digit + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_BLANK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segment_scanner.sv
// Directed bench for segment_scanner with NDIGITS=4, DWELL=4, BLANK=2
// (digit period 6 cycles, frame period 24 cycles).
module tb_segment_scanner;
  import simple_pkg::*;

  logic        clock;
  logic        resetn;
  logic [31:0] digit_in;
  logic [3:0]  raw_mask;
  logic        freeze;
  logic [7:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_pulse;
  logic [1:0]  cur_digit;

  int errors = 0;
  int checks = 0;

  segment_scanner #(
    .NDIGITS (4),
    .DWELL   (4),
    .BLANK   (2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .digit_in    (digit_in),
    .raw_mask    (raw_mask),
    .freeze      (freeze),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .frame_pulse (frame_pulse),
    .cur_digit   (cur_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    check("sel_onehot0", 32'((digit_sel == 4'b0) || $onehot(digit_sel)), 32'd1);
    if (digit_sel == 4'b0) check("blank_seg", 32'(segments), 32'd0);
  end

  // Steps n = 1..last_n edges after a reload edge; digit k is on for n in
  // [2+6k, 5+6k]. At n == change_at the new inputs are driven.
  task automatic frame_check(input string tag,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3,
                             input int last_n, input int change_at,
                             input logic [31:0] ndin, input logic [3:0] nraw,
                             input logic nfrz);
    logic [7:0] pats [4];
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;
    int         k;
    pats = '{p0, p1, p2, p3};
    for (int n = 1; n <= last_n; n++) begin
      step();
      exp_seg = 8'h00;
      exp_sel = 4'b0000;
      if (n >= 2 && ((n - 2) % 6) < 4) begin
        k       = (n - 2) / 6;
        exp_seg = pats[k];
        exp_sel = 4'b0001 << k;
      end
      check($sformatf("%s seg n=%0d", tag, n), 32'(segments), 32'(exp_seg));
      check($sformatf("%s sel n=%0d", tag, n), 32'(digit_sel), 32'(exp_sel));
      check($sformatf("%s cur n=%0d", tag, n), 32'(cur_digit), (n < 24) ? 32'(n / 6) : 32'd0);
      check($sformatf("%s pulse n=%0d", tag, n), 32'(frame_pulse), (n == 24) ? 32'd1 : 32'd0);
      if (n == change_at) begin
        digit_in = ndin;
        raw_mask = nraw;
        freeze   = nfrz;
      end
    end
  endtask

  localparam logic [31:0] SET1 = {SEG_E, SEG_H, SEG_F, SEG_O};
  localparam logic [31:0] SET2 = {8'hEF, 8'h18, 8'h00, 8'h1A};
  localparam logic [31:0] SET3 = {8'h08, 8'h6E, 8'h01, 8'hA5};
  localparam logic [31:0] SET4 = 32'hFFFF_FFFF;

  initial begin
    resetn   = 1'b0;
    digit_in = SET1;
    raw_mask = 4'b1111;
    freeze   = 1'b0;
    #12;
    check("rst seg", 32'(segments), 32'd0);
    check("rst sel", 32'(digit_sel), 32'd0);
    check("rst pulse", 32'(frame_pulse), 32'd0);
    check("rst cur", 32'(cur_digit), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    step();
    check("init seg", 32'(segments), 32'd0);
    check("init sel", 32'(digit_sel), 32'd0);
    check("init pulse", 32'(frame_pulse), 32'd0);

    // Frame A: raw glyphs O F H E; new data arrives while digit 1 is shown
    frame_check("A", 8'b00111010, 8'b10001110, 8'b01101110, 8'b10011110,
                24, 10, SET2, 4'b0000, 1'b0);
    // Frame B: hex decode; digit0 0x1A -> A with dp, bits 7..5 ignored on digit3
    frame_check("B", 8'b11101111, 8'b11111100, 8'b11111111, 8'b10001110,
                24, 10, SET3, 4'b0101, 1'b1);
    // Frames C, D: frozen, inputs keep changing
    frame_check("C", 8'b11101111, 8'b11111100, 8'b11111111, 8'b10001110,
                24, 10, SET4, 4'b1111, 1'b1);
    frame_check("D", 8'b11101111, 8'b11111100, 8'b11111111, 8'b10001110,
                24, 10, SET3, 4'b0101, 1'b0);
    // Frame E: freeze released, mixed raw / decoded digits
    frame_check("E", 8'b10100101, 8'b01100000, 8'b01101110, 8'b11111110,
                24, 0, SET3, 4'b0101, 1'b0);
    // Frame F: stop while digit 2 is being scanned
    frame_check("F", 8'b10100101, 8'b01100000, 8'b01101110, 8'b11111110,
                15, 0, SET3, 4'b0101, 1'b0);

    #3;
    resetn = 1'b0;
    #1;
    check("async seg", 32'(segments), 32'd0);
    check("async sel", 32'(digit_sel), 32'd0);
    check("async cur", 32'(cur_digit), 32'd0);
    freeze = 1'b1;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    step();
    check("rst2 seg", 32'(segments), 32'd0);
    check("rst2 sel", 32'(digit_sel), 32'd0);
    // Reload skipped: reset shadow (raw, all zero) gives a blank display
    frame_check("G", 8'h00, 8'h00, 8'h00, 8'h00, 24, 0, SET3, 4'b0101, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
